layer_output_serializer: RTL and testbench
==========================================

Name: layer_output_serializer

Overview:
- Sits at the output of a neuron layer and feeds the next layer.
- Collects the NUM_NEURONS parallel results, each arriving with its own out_valid pulse.
- Once all results are held, streams them one word per handshake onto the single broadcast data bus that the next layer's neurons consume.
- Provides the word index, so the next layer can address its weight memories, and a done pulse per completed frame.

Parameters:
- NUM_NEURONS, 30, number of upstream neurons and words per frame (≥1)
- data_width, 16, width of each neuron result and of the output word (signed two's complement)
- IDX_W, $clog2(NUM_NEURONS) with minimum 1, width of out_index

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-low reset; clears all state immediately, released synchronously by the integrator
- layer_in  input  NUM_NEURONS*data_width  packed neuron results; word i occupies bits [i*data_width +: data_width]
- in_valid  input  NUM_NEURONS  per-neuron valid; bit i high for ≥1 cycle when word i is valid
- out_data  output  data_width  current serialized word
- out_valid  output  1  out_data/out_index valid
- out_ready  input  1  downstream accepts the word when out_valid and out_ready are both high at a clock edge
- out_index  output  IDX_W  neuron index of out_data, 0..NUM_NEURONS-1
- frame_done  output  1  one-cycle pulse after the last word is accepted
- busy  output  1  high while in SEND
- overrun  output  1  sticky error flag

Behaviour:
- Reset (rst=0, asynchronous):
  - state=COLLECT, mask=0, idx=0.
  - out_valid=0, out_index=0, frame_done=0, busy=0, overrun=0.
  - out_data=0; capture buffer cleared to 0.
- Two states: COLLECT and SEND. busy = (state==SEND); out_valid = (state==SEND); out_index = idx; out_data = buf[idx]. All of these are driven from registers only.
- COLLECT:
  - For each i with in_valid[i]=1 and mask[i]=0 at an edge: buf[i] <= layer_in word i; mask[i] <= 1. Multiple bits may capture in the same cycle.
  - in_valid[i]=1 while mask[i]=1: the word is ignored (first capture kept) and overrun <= 1.
  - When the updated mask becomes all ones, state <= SEND at that same edge, so out_valid rises the cycle after the final capture. Minimum latency, all in_valid high in one cycle: 1 cycle to out_valid.
- SEND:
  - out_valid is held high, and out_data/out_index stay stable, until accepted.
  - Accept with idx < NUM_NEURONS-1: idx <= idx+1. Back-to-back accepts give one word per cycle.
  - Accept with idx == NUM_NEURONS-1: state <= COLLECT, idx <= 0, mask <= 0, frame_done <= 1 for exactly one cycle. out_valid is low in that cycle.
  - out_ready is ignored when out_valid=0.
  - Any in_valid bit high in SEND: data is not captured and overrun <= 1. This includes the final-accept cycle, because mask clears at that edge.
- overrun is cleared only by reset.
- NUM_NEURONS=1: a single capture goes to SEND; one accept returns to COLLECT with frame_done.
- Reset mid-frame: partial mask and any in-progress SEND are discarded; no frame_done is issued.
- Word order is always ascending index 0..NUM_NEURONS-1, regardless of capture order.

Optional Feature:
- Macro: LAYER_SER_RELU_EN.
- Defined: out_data = 0 when buf[idx] has its MSB set (negative); otherwise out_data = buf[idx]. This applies ReLU between layers with no added latency. The stored buffer is unmodified.
- Not defined: out_data = buf[idx] unchanged.
- Handshake and timing are identical in both builds.

Test Plan:
- NUM_NEURONS=4, data_width=16. Pulse in_valid=4'b1111 for one cycle with words 0x0010, 0x0020, 0xFFF0, 0x0040; out_ready held 1 -> out_valid rises 1 cycle later. out_index 0,1,2,3 on consecutive cycles with data 0x0010, 0x0020, 0xFFF0, 0x0040 (0x0000 at index 2 with LAYER_SER_RELU_EN). frame_done pulses once. busy low afterwards.
- Staggered capture: in_valid bits 3, 1, 0, 2 on separate cycles -> no out_valid until the bit-2 capture edge. Output order is still index 0..3.
- Backpressure: out_ready toggles 1,0,0,1,... -> out_index advances only on ready cycles. out_data is stable while stalled. Exactly 4 accepts, then frame_done.
- Overrun: in_valid[1] pulsed twice in COLLECT with 0x0111 then 0x0222 -> word 1 sent as 0x0111 and overrun=1. A separate run pulsing in_valid[0] during SEND -> overrun=1 and the frame is unaffected.
- Reset mid-SEND: assert rst after index 1 is accepted -> out_valid, busy, frame_done and overrun go 0 immediately. A fresh frame after release starts at index 0.
- Back-to-back frames: a second full capture following frame_done -> second frame streams correctly with no stale data from the first.

Source files
------------

// File: rtl/layer_output_serializer.sv
// Collects NUM_NEURONS parallel neuron results, then streams them in index order over a valid/ready bus.
// Optional build macro LAYER_SER_RELU_EN applies ReLU to each outgoing word without adding latency.
module layer_output_serializer #(
    parameter int NUM_NEURONS = 30,
    parameter int data_width  = 16,
    parameter int IDX_W       = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_NEURONS*data_width-1:0] layer_in,
    input  logic [NUM_NEURONS-1:0]            in_valid,
    output logic [data_width-1:0]             out_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [IDX_W-1:0]                  out_index,
    output logic                              frame_done,
    output logic                              busy,
    output logic                              overrun
);

    typedef enum logic {COLLECT, SEND} state_t;

    state_t                        state;
    logic [NUM_NEURONS-1:0]        mask;
    logic [NUM_NEURONS-1:0]        mask_nxt;
    logic signed [data_width-1:0]  cap_buf [NUM_NEURONS];
    logic signed [data_width-1:0]  cap_nxt [NUM_NEURONS];
    logic [IDX_W-1:0]              idx;
    logic [IDX_W-1:0]              idx_nxt;
    logic                          ovr_hit;
    logic                          accept;
    logic                          last_word;

    function automatic logic [data_width-1:0] relu(input logic signed [data_width-1:0] x);
`ifdef LAYER_SER_RELU_EN
        return x[data_width-1] ? '0 : x;
`else
        return x;
`endif
    endfunction

    assign out_index = idx;
    assign accept    = (state == SEND) && out_ready;
    assign last_word = (idx == IDX_W'(NUM_NEURONS - 1));

    always_comb begin
        cap_nxt  = cap_buf;
        mask_nxt = mask;
        ovr_hit  = 1'b0;
        idx_nxt  = idx;
        if (state == COLLECT) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                if (in_valid[i]) begin
                    if (mask[i]) begin
                        ovr_hit = 1'b1;
                    end else begin
                        cap_nxt[i]  = layer_in[i*data_width +: data_width];
                        mask_nxt[i] = 1'b1;
                    end
                end
            end
        end else begin
            ovr_hit = |in_valid;
            if (accept) begin
                idx_nxt = last_word ? '0 : idx + 1'b1;
            end
        end
    end

    // Output word is registered from the next-cycle buffer/index so it lines up with out_index.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= COLLECT;
            mask       <= '0;
            idx        <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                cap_buf[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                cap_buf[i] <= cap_nxt[i];
            end
            mask       <= mask_nxt;
            idx        <= idx_nxt;
            out_data   <= relu(cap_nxt[idx_nxt]);
            overrun    <= overrun | ovr_hit;
            frame_done <= 1'b0;
            case (state)
                COLLECT: begin
                    if (&mask_nxt) begin
                        state     <= SEND;
                        busy      <= 1'b1;
                        out_valid <= 1'b1;
                    end
                end
                SEND: begin
                    if (accept && last_word) begin
                        state      <= COLLECT;
                        mask       <= '0;
                        busy       <= 1'b0;
                        out_valid  <= 1'b0;
                        frame_done <= 1'b1;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_layer_output_serializer.sv
// Self-checking bench for layer_output_serializer (NUM_NEURONS=4, data_width=16) against a frame-level model.
module tb_layer_output_serializer;
    localparam int N = 4;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N*W-1:0] layer_in = '0;
    logic [N-1:0]   in_valid = '0;
    logic           out_ready = 1'b0;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic [1:0]     out_index;
    logic           frame_done;
    logic           busy;
    logic           overrun;

    layer_output_serializer #(.NUM_NEURONS(N), .data_width(W)) dut (
        .clk(clk), .rst(rst), .layer_in(layer_in), .in_valid(in_valid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_index(out_index), .frame_done(frame_done), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int dut_accepts = 0;

    logic [W-1:0] words [N];

    // Frame-level reference: which words are held, the frame being sent, send position.
    bit           m_have [N];
    logic [W-1:0] m_val  [N];
    bit           m_send, m_done, m_ovr;
    int           m_pos;

    function automatic logic [W-1:0] exp_word(input logic [W-1:0] w);
`ifdef LAYER_SER_RELU_EN
        return w[W-1] ? '0 : w;
`else
        return w;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_have[i] = 0;
            m_val[i]  = '0;
        end
        m_send = 0; m_done = 0; m_ovr = 0; m_pos = 0;
    endtask

    task automatic model_edge(input logic [N-1:0] iv, input logic rdy);
        bit all;
        m_done = 0;
        if (!m_send) begin
            for (int i = 0; i < N; i++) begin
                if (iv[i]) begin
                    if (m_have[i]) m_ovr = 1;
                    else begin
                        m_have[i] = 1;
                        m_val[i]  = words[i];
                    end
                end
            end
            all = 1;
            for (int i = 0; i < N; i++) all &= m_have[i];
            if (all) begin
                m_send = 1;
                m_pos  = 0;
            end
        end else begin
            if (iv != 0) m_ovr = 1;
            if (rdy) begin
                if (m_pos == N - 1) begin
                    m_send = 0;
                    m_done = 1;
                    m_pos  = 0;
                    for (int i = 0; i < N; i++) m_have[i] = 0;
                end else begin
                    m_pos++;
                end
            end
        end
    endtask

    task automatic check_outputs();
        check("out_valid", out_valid, m_send);
        check("busy", busy, m_send);
        check("frame_done", frame_done, m_done);
        check("overrun", overrun, m_ovr);
        if (m_send) begin
            check("out_index", out_index, m_pos);
            check("out_data", out_data, exp_word(m_val[m_pos]));
        end
    endtask

    task automatic step(input logic [N-1:0] iv, input logic rdy);
        for (int i = 0; i < N; i++) layer_in[i*W +: W] = words[i];
        in_valid  = iv;
        out_ready = rdy;
        if (out_valid && rdy) dut_accepts++;
        @(posedge clk);
        model_edge(iv, rdy);
        #1;
        check_outputs();
    endtask

    task automatic check_reset_state();
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_overrun", overrun, 0);
        check("rst_out_index", out_index, 0);
        check("rst_out_data", out_data, 0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        in_valid = '0;
        #1;
        model_reset();
        check_reset_state();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic rand_words();
        for (int i = 0; i < N; i++) words[i] = W'($urandom);
    endtask

    // mode 0: ready always, 1: random ready plus stray in_valid, 2: ready pattern 1,0,0
    task automatic drain(input int mode);
        logic       rdy;
        logic [N-1:0] iv;
        for (int c = 0; c < 60 && m_send; c++) begin
            iv  = '0;
            rdy = 1'b1;
            if (mode == 1) begin
                rdy = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 7) == 0) iv = N'($urandom);
                rand_words();
            end else if (mode == 2) begin
                rdy = (c % 3 == 0);
            end
            step(iv, rdy);
        end
        check("drain_done", out_valid, 0);
    endtask

    initial begin
        logic [W-1:0] t1 [N];
        model_reset();
        for (int i = 0; i < N; i++) words[i] = '0;
        do_reset();

        // Single-cycle capture of all four words
        words[0] = 16'h0010; words[1] = 16'h0020; words[2] = 16'hFFF0; words[3] = 16'h0040;
        t1[0] = 16'h0010; t1[1] = 16'h0020; t1[3] = 16'h0040;
`ifdef LAYER_SER_RELU_EN
        t1[2] = 16'h0000;
`else
        t1[2] = 16'hFFF0;
`endif
        step(4'hF, 1'b1);
        check("t1_valid", out_valid, 1);
        check("t1_d0", out_data, t1[0]);
        for (int j = 1; j < N; j++) begin
            step(4'h0, 1'b1);
            check("t1_idx", out_index, j);
            check("t1_data", out_data, t1[j]);
        end
        step(4'h0, 1'b1);
        check("t1_done", frame_done, 1);
        step(4'h0, 1'b1);
        check("t1_idle", busy, 0);

        // Staggered capture 3,1,0,2
        rand_words(); step(4'b1000, 1'b1);
        rand_words(); step(4'b0010, 1'b1);
        rand_words(); step(4'b0001, 1'b1);
        check("stag_wait", out_valid, 0);
        rand_words(); step(4'b0100, 1'b1);
        check("stag_go", out_valid, 1);
        drain(0);

        // Backpressure
        rand_words(); step(4'hF, 1'b0);
        dut_accepts = 0;
        drain(2);
        check("bp_accepts", dut_accepts, 4);
        check("bp_done", frame_done, 1);

        // Duplicate capture in COLLECT keeps the first word
        do_reset();
        rand_words(); words[1] = 16'h0111; step(4'b0010, 1'b1);
        words[1] = 16'h0222; step(4'b0010, 1'b1);
        check("ovr_collect", overrun, 1);
        step(4'b1101, 1'b1);
        step(4'h0, 1'b1);
        check("ovr_keep", out_data, 16'h0111);
        drain(0);

        // in_valid during SEND
        do_reset();
        rand_words(); step(4'hF, 1'b0);
        rand_words(); step(4'b0001, 1'b1);
        check("ovr_send", overrun, 1);
        drain(0);

        // Reset mid-SEND after index 1 accepted, with overrun already set
        do_reset();
        rand_words(); step(4'hF, 1'b1);
        step(4'b0001, 1'b1);
        step(4'h0, 1'b1);
        check("mid_idx", out_index, 2);
        do_reset();
        rand_words(); step(4'hF, 1'b1);
        check("fresh_idx", out_index, 0);
        drain(0);

        // Back-to-back frames
        rand_words(); step(4'hF, 1'b1); drain(0);
        rand_words(); step(4'hF, 1'b1); drain(0);

        // Randomized frames
        for (int f = 0; f < 20; f++) begin
            for (int c = 0; c < 40 && !m_send; c++) begin
                rand_words();
                step(N'($urandom), 1'($urandom_range(0, 1)));
            end
            check("rand_capture", out_valid, 1);
            drain(1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
